// File: rtl/lsu_pkg.sv
// Shared MemOp encodings, FSM state type and request legality check for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StMerge,
    StWr,
    StResp,
    StErr
  } state_e;

  // High when the request is an illegal op for its direction or is misaligned.
  function automatic logic req_bad(input logic wr, input logic [2:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      MEM_B:   bad = 1'b0;
      MEM_H:   bad = lo[0];
      MEM_W:   bad = |lo;
      MEM_BU:  bad = wr;
      MEM_HU:  bad = wr | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake and data-RAM bus of the load/store unit.
interface lsu_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Execute stage plus data RAM: issues requests, returns read data.
  modport master (
    output req_valid, req_wr, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, req_wr, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_ext.sv
// Picks the byte/half/word lane of a RAM word and sign- or zero-extends it to 32 bits.
module lsu_lane_ext
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (op)
      MEM_B:   ext = {{24{byte_sel[7]}}, byte_sel};
      MEM_H:   ext = {{16{half_sel[15]}}, half_sel};
      MEM_W:   ext = word;
      MEM_BU:  ext = {24'h0, byte_sel};
      MEM_HU:  ext = {16'h0, half_sel};
      default: ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: lane-extracting loads, direct word stores and read-modify-write sub-word
// stores against a word-wide synchronous RAM without byte enables.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_ctrl_if.slave bus
);

  state_e            state_q;
  logic              wr_q;
  logic [2:0]        op_q;
  logic [1:0]        lane_q;
  logic [15:0]       wdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [31:0]       mem_wdata_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;

  logic        accept;
  logic        bad;
  logic [31:0] merged;
  logic [31:0] load_ext;
  logic        unused_addr_hi;

  assign accept         = bus.req_valid & bus.req_ready;
  assign bad            = req_bad(bus.req_wr, bus.req_op, bus.req_addr[1:0]);
  // The RAM only decodes ADDR_W word-address bits; higher bits wrap.
  assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

  always_comb begin
    merged = bus.mem_rdata;
    if (op_q == MEM_B) begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  lsu_lane_ext u_lane_ext (
    .word (bus.mem_rdata),
    .lane (lane_q),
    .op   (op_q),
    .ext  (load_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      op_q        <= 3'b000;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            wr_q    <= bus.req_wr;
            op_q    <= bus.req_op;
            lane_q  <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata[15:0];
            if (bad) begin
              state_q     <= StErr;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              mem_addr_q <= bus.req_addr[ADDR_W+1:2];
              if (bus.req_wr && bus.req_op == MEM_W) begin
                state_q     <= StWr;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= bus.req_wdata;
              end else begin
                state_q <= StRd;
              end
            end
          end
        end
        StRd: begin
          if (wr_q) begin
            state_q <= StMerge;
          end else begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
          end
        end
        StMerge: begin
          state_q     <= StWr;
          mem_we_q    <= 1'b1;
          mem_wdata_q <= merged;
        end
        StWr: begin
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
        end
        StResp:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gating with rst aborts an in-flight write or response in the reset cycle itself.
  assign bus.req_ready = (state_q == StIdle) & ~rst;
  assign bus.mem_we    = mem_we_q & ~rst;
  assign bus.rsp_valid = rsp_valid_q & ~rst;
  assign bus.rsp_err   = rsp_err_q & ~rst;
  assign bus.rsp_rdata = (state_q == StResp && !wr_q && !rst) ? load_ext : 32'h0;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
